i2c_init_sequencer: RTL

I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

---
 rtl/i2c_init_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/i2c_init_sequencer.sv
// Plays a register-write table out to an I2C master, one handshake per entry,
// with an idle gap between transfers and a timeout on master acceptance.
module i2c_init_sequencer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_addr,
    input  logic [23:0]   tbl_wdata,
    input  logic          go,
    input  logic [AW:0]   len,
    input  logic          m_ready,
    output logic          m_start,
    output logic [7:0]    m_dev_id,
    output logic [7:0]    m_reg_id,
    output logic [7:0]    m_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] idx
);

    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [GW-1:0] GLAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [AW:0]   LMAX  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_ACCEPT,
        S_COMPLETE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [23:0]   fld_q, fld_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;

    // Table is never reset; the in-flight copy lives in fld_q
    logic [23:0]   tbl_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset && tbl_we && (32'(tbl_addr) < DEPTH)) begin
            tbl_q[tbl_addr] <= tbl_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        fld_d   = fld_q;
        start_d = start_q;
        done_d  = 1'b0;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            S_IDLE: begin
                start_d = 1'b0;
                if (go) begin
                    if ((len != '0) && (len <= LMAX)) begin
                        len_d   = len;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                fld_d   = tbl_q[idx_q];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (m_ready) begin
                    start_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (!m_ready) begin
                    start_d = 1'b0;
                    state_d = S_COMPLETE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_d >= TMAX) begin
                        err_d   = 1'b1;
                        start_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_COMPLETE: begin
                if (m_ready) begin
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // GLAST is 0 for a zero gap, so the state still lasts one cycle
                if (gcnt_q == GLAST) begin
                    if ({1'b0, idx_q} == (len_q - 1'b1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            fld_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            fld_q   <= fld_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign m_start  = start_q;
    assign m_dev_id = fld_q[23:16];
    assign m_reg_id = fld_q[15:8];
    assign m_data   = fld_q[7:0];
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign error    = err_q;
    assign idx      = idx_q;

endmodule
